or_share_arbiter: RTL and testbench

// - Shares one DATA_W-bit 2-input OR datapath among NUM_REQ requesters.
// - Round-robin arbitration with registered one-hot grant; operands of the winner are latched,

---
 rtl/or_share_pkg.sv | 12 +
 rtl/myOR.sv | 10 +
 rtl/rr_pick.sv | 35 +++
 rtl/or_share_arbiter.sv | 108 ++++++++++
 tb/tb_or_share_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/or_share_pkg.sv
// Shared constants and width helpers for the OR-sharing arbiter.
package or_share_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 4;

    // Requester-index width. Never returns less than 1, so a two-requester build still gets a real ID bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 32'(1) : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/myOR.sv
// Single-bit 2-input OR gate cell used as the shared datapath slice.
module myOR (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a | b;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of elig at or after ptr, wrapping.
module rr_pick
    import or_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    localparam int unsigned IDX_W = ID_W + 1;

    logic [IDX_W-1:0] idx;

    // Walk the candidates from ptr, wrapping at NUM_REQ, and keep the first eligible one.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!found && elig[idx[ID_W-1:0]]) begin
                winner = idx[ID_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/or_share_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit OR datapath among NUM_REQ requesters.
// Stage 1 registers the grant plus the winner's operands; stage 2 registers the OR result.
module or_share_arbiter
    import or_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter  int unsigned DATA_W  = DEF_DATA_W,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] in1_flat,
    input  logic [NUM_REQ*DATA_W-1:0] in2_flat,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id
);

    logic [NUM_REQ-1:0] elig_c;
    logic [ID_W-1:0]    win_c;
    logic               found_c;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next_c;
    logic [NUM_REQ-1:0] gnt_next_c;
    logic [DATA_W-1:0]  sel_a_c;
    logic [DATA_W-1:0]  sel_b_c;
    logic [DATA_W-1:0]  opa_q;
    logic [DATA_W-1:0]  opb_q;
    logic [ID_W-1:0]    id_q;
    logic               v1;
    logic [DATA_W-1:0]  or_c;

    // The requester granted last cycle is masked so nobody is granted back-to-back.
    assign elig_c = req & ~gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .elig   (elig_c),
        .ptr    (ptr),
        .winner (win_c),
        .found  (found_c)
    );

    assign gnt_next_c = NUM_REQ'(1) << win_c;
    assign ptr_next_c = (win_c == ID_W'(NUM_REQ - 1)) ? '0 : win_c + ID_W'(1);

    // Select the winner's operand slices.
    always_comb begin
        sel_a_c = '0;
        sel_b_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_c == ID_W'(i)) begin
                sel_a_c = in1_flat[i*DATA_W +: DATA_W];
                sel_b_c = in2_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage 1: grant, round-robin pointer and operand capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt   <= '0;
            ptr   <= '0;
            opa_q <= '0;
            opb_q <= '0;
            id_q  <= '0;
            v1    <= 1'b0;
        end else if (found_c) begin
            gnt   <= gnt_next_c;
            ptr   <= ptr_next_c;
            opa_q <= sel_a_c;
            opb_q <= sel_b_c;
            id_q  <= win_c;
            v1    <= 1'b1;
        end else begin
            gnt <= '0;
            v1  <= 1'b0;
        end
    end

    // Shared OR datapath, one gate cell per bit.
    for (genvar b = 0; b < DATA_W; b++) begin : g_or
        myOR u_or (
            .a (opa_q[b]),
            .b (opb_q[b]),
            .y (or_c[b])
        );
    end

    // Stage 2: result register; data and ID hold while no result is valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out_data <= or_c;
                out_id   <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_or_share_arbiter.sv
// Scoreboard bench for or_share_arbiter: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_or_share_arbiter;

    typedef struct {
        int         c;
        logic [3:0] g;
    } gexp_t;

    typedef struct {
        int         c;
        bit         v;
        logic [1:0] id;
        logic [3:0] d;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [15:0] in1_flat;
    logic [15:0] in2_flat;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;

    logic [3:0]  in1_arr [4];
    logic [3:0]  in2_arr [4];
    logic [3:0]  exp_or  [4];

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    gexp_t gq[$];
    rexp_t rq[$];

    or_share_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in1_flat  (in1_flat),
        .in2_flat  (in2_flat),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign in1_flat[i*4 +: 4] = in1_arr[i];
        assign in2_flat[i*4 +: 4] = in2_arr[i];
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic push_g(input int c, input logic [3:0] g);
        gexp_t e;
        e.c = c;
        e.g = g;
        gq.push_back(e);
    endtask

    task automatic push_r(input int c, input bit v, input int id);
        rexp_t e;
        e.c  = c;
        e.v  = v;
        e.id = 2'(id);
        e.d  = exp_or[id];
        rq.push_back(e);
    endtask

    // Drive req for one cycle; expect grant g next cycle and (optionally) its result the cycle after.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input int id, input bit res);
        @(negedge clk);
        req = r;
        push_g(cyc + 1, g);
        if (res) push_r(cyc + 2, g != 4'b0000, id);
    endtask

    // Monitor: compare outputs against the expectation tagged for the current cycle.
    initial begin
        gexp_t ge;
        rexp_t re;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (gq.size() != 0 && gq[0].c < cyc) begin
                    ge = gq.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL gnt_missed: expectation for cycle %0d not reached, now %0d", ge.c, cyc);
                end
                if (gq.size() != 0 && gq[0].c == cyc) begin
                    ge = gq.pop_front();
                    chk("gnt", 32'(gnt), 32'(ge.g));
                end else begin
                    chk("gnt_idle", 32'(gnt), 32'(0));
                end
                while (rq.size() != 0 && rq[0].c < cyc) begin
                    re = rq.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL result_missed: expectation for cycle %0d not reached, now %0d", re.c, cyc);
                end
                if (rq.size() != 0 && rq[0].c == cyc) begin
                    re = rq.pop_front();
                    chk("out_valid", 32'(out_valid), 32'(re.v));
                    if (re.v) begin
                        chk("out_id", 32'(out_id), 32'(re.id));
                        chk("out_data", 32'(out_data), 32'(re.d));
                    end
                end else begin
                    chk("out_valid_idle", 32'(out_valid), 32'(0));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d, expected under 10000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        in1_arr[0] = 4'b0001; in2_arr[0] = 4'b0100; exp_or[0] = 4'b0101;
        in1_arr[1] = 4'b1010; in2_arr[1] = 4'b0101; exp_or[1] = 4'b1111;
        in1_arr[2] = 4'b0011; in2_arr[2] = 4'b0000; exp_or[2] = 4'b0011;
        in1_arr[3] = 4'b1000; in2_arr[3] = 4'b1001; exp_or[3] = 4'b1001;

        // Reset held two cycles with every requester asking.
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_id", 32'(out_id), 32'(0));
        rst_n  = 1'b1;
        req    = 4'b0000;
        mon_en = 1'b1;

        // Rotation: each requester drops req after its grant, re-raises the next cycle.
        step(4'b1111, 4'b0001, 0, 1'b1);
        step(4'b1110, 4'b0010, 1, 1'b1);
        step(4'b1101, 4'b0100, 2, 1'b1);
        step(4'b1011, 4'b1000, 3, 1'b1);
        step(4'b0111, 4'b0001, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);

        // Single requester 1; its operands change after the grant edge and must not leak in.
        step(4'b0010, 4'b0010, 1, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);
        in1_arr[1] = 4'b0000;
        step(4'b0000, 4'b0000, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);
        in1_arr[1] = 4'b1010;

        // Fairness: 0 and 3 held; pointer sits at 2, so 3 wins first, then they alternate.
        step(4'b1001, 4'b1000, 3, 1'b1);
        step(4'b1001, 4'b0001, 0, 1'b1);
        step(4'b1001, 4'b1000, 3, 1'b1);
        step(4'b1001, 4'b0001, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);

        // Mask: requester 2 held alone is granted every other cycle.
        step(4'b0100, 4'b0100, 2, 1'b1);
        step(4'b0100, 4'b0000, 0, 1'b1);
        step(4'b0100, 4'b0100, 2, 1'b1);
        step(4'b0100, 4'b0000, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);

        // Reset during the grant cycle of requester 2: its result is dropped.
        step(4'b0100, 4'b0100, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        push_g(cyc + 1, 4'b0000);
        push_r(cyc + 1, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_g(cyc + 1, 4'b0001);
        push_r(cyc + 1, 1'b0, 0);
        push_r(cyc + 2, 1'b1, 0);
        step(4'b0000, 4'b0000, 0, 1'b1);
        step(4'b0000, 4'b0000, 0, 1'b1);

        for (int i = 0; i < 20 && (gq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
        if (gq.size() != 0 || rq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d grant and %0d result expectations pending, expected 0",
                     gq.size(), rq.size());
        end
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
